// File: rtl/cache_miss_controller_pkg.sv
// rtl/cache_miss_controller_pkg.sv - shared constants and FSM state encoding for the miss controller
package cache_miss_controller_pkg;

  localparam int TAG_W   = 24;
  localparam int INDEX_W = 3;
  localparam int WAYS    = 4;
  localparam int SETS    = 1 << INDEX_W;
  localparam int ADDR_W  = TAG_W + INDEX_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    FILL      = 3'd4,
    RESP      = 3'd5
  } state_e;

endpackage

// File: rtl/cache_miss_controller_plru_tree4.sv
// rtl/cache_miss_controller_plru_tree4.sv - per-set 3-bit tree pseudo-LRU state for a 4-way cache
module plru_tree4
  import cache_miss_controller_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic [1:0]         victim_o,
  input  logic               touch_en_i,
  input  logic [INDEX_W-1:0] touch_index_i,
  input  logic [1:0]         touch_way_i
);

  // Bit layout {b2,b1,b0}: b0 picks the half, b1/b2 pick within ways 0/1 and 2/3.
  logic [2:0] bits_q [SETS];
  logic [2:0] rd_bits;

  assign rd_bits  = bits_q[rd_index_i];
  assign victim_o = rd_bits[0] ? {1'b1, rd_bits[2]} : {1'b0, rd_bits[1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        bits_q[s] <= '0;
      end
    end else if (touch_en_i) begin
      bits_q[touch_index_i][0] <= ~touch_way_i[1];
      if (!touch_way_i[1]) begin
        bits_q[touch_index_i][1] <= ~touch_way_i[0];
      end else begin
        bits_q[touch_index_i][2] <= ~touch_way_i[0];
      end
    end
  end

endmodule

// File: rtl/cache_miss_controller.sv
// rtl/cache_miss_controller.sv - lookup/miss sequencing FSM between pipeline, tag store and memory
module cache_miss_controller
  import cache_miss_controller_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [TAG_W-1:0]   req_tag_i,
  input  logic [INDEX_W-1:0] req_index_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_hit_o,
  output logic [1:0]         rsp_way_o,
  output logic [TAG_W-1:0]   ts_tag_o,
  output logic [INDEX_W-1:0] ts_index_o,
  output logic [1:0]         ts_way_o,
  output logic               ts_replace_o,
  input  logic               ts_hit_i,
  input  logic [1:0]         ts_way_hit_i,
  input  logic [3:0]         ts_valid_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [ADDR_W-1:0]  mem_req_addr_o,
  input  logic               mem_rsp_valid_i
);

  state_e             state_q;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  logic [1:0]         victim_q;
  logic [1:0]         victim_d;
  logic [1:0]         plru_victim;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_hit_q;
  logic [1:0]         rsp_way_q;
  logic [1:0]         ts_way_q;
  logic               ts_replace_q;
  logic               mem_req_valid_q;
  logic               touch_en;
  logic [1:0]         touch_way;

  assign req_ready_o     = req_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_hit_o       = rsp_hit_q;
  assign rsp_way_o       = rsp_way_q;
  assign ts_tag_o        = tag_q;
  assign ts_index_o      = index_q;
  assign ts_way_o        = ts_way_q;
  assign ts_replace_o    = ts_replace_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = {tag_q, index_q};

  // LOOKUP-hit and FILL are mutually exclusive states, so one touch per cycle at most.
  assign touch_en  = (state_q == LOOKUP && ts_hit_i) || (state_q == FILL);
  assign touch_way = (state_q == FILL) ? victim_q : ts_way_hit_i;

  plru_tree4 u_plru (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rd_index_i    (index_q),
    .victim_o      (plru_victim),
    .touch_en_i    (touch_en),
    .touch_index_i (index_q),
    .touch_way_i   (touch_way)
  );

  // Lowest-numbered invalid way wins; PLRU only decides when the set is full.
  always_comb begin
    victim_d = plru_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!ts_valid_i[w]) begin
        victim_d = w[1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      tag_q           <= '0;
      index_q         <= '0;
      victim_q        <= '0;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_way_q       <= '0;
      ts_way_q        <= '0;
      ts_replace_q    <= 1'b0;
      mem_req_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            tag_q       <= req_tag_i;
            index_q     <= req_index_i;
            req_ready_q <= 1'b0;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (ts_hit_i) begin
            rsp_hit_q   <= 1'b1;
            rsp_way_q   <= ts_way_hit_i;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            victim_q        <= victim_d;
            mem_req_valid_q <= 1'b1;
            state_q         <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem_rsp_valid_i) begin
            ts_way_q     <= victim_q;
            ts_replace_q <= 1'b1;
            state_q      <= FILL;
          end
        end
        FILL: begin
          ts_replace_q <= 1'b0;
          rsp_hit_q    <= 1'b0;
          rsp_way_q    <= victim_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
